// File: rtl/npu_sigmoid_collector_pkg.sv
// npu_sigmoid_collector_pkg: shared NPU widths, destination and output-FSM encodings
package npu_sigmoid_collector_pkg;
  localparam int NPU_DATA_W   = 16;
  localparam int NPU_CNT_W    = 8;
  localparam int NPU_FB_DEPTH = 16;
  typedef enum logic {DEST_FB = 1'b0, DEST_OUT = 1'b1} dest_e;
  typedef enum logic {ST_PASS = 1'b0, ST_HOLD = 1'b1} out_state_e;
  function automatic int fb_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/npu_sigmoid_collector_if.sv
// npu_sigmoid_collector_if: sigmoid input, feedback FIFO and output FIFO signals of the collector
interface npu_sigmoid_collector_if
  import npu_sigmoid_collector_pkg::*;
#(
  parameter int DATA_W = NPU_DATA_W,
  parameter int CNT_W  = NPU_CNT_W,
  parameter int FB_CW  = fb_cw(NPU_FB_DEPTH)
);
  logic [DATA_W-1:0] npu_sigmoid_dout;
  logic              npu_sigmoid_dout_valid;
  logic              npu_sched_sigmoid_dest_sel;
  logic [CNT_W-1:0]  npu_sched_layer_size;
  logic              npu_fb_fifo_rd_en;
  logic [DATA_W-1:0] npu_fb_fifo_dout;
  logic              npu_fb_fifo_empty;
  logic              npu_fb_fifo_full;
  logic [FB_CW-1:0]  npu_fb_fifo_count;
  logic              npu_out_fifo_full;
  logic              npu_out_fifo_wr_en;
  logic [DATA_W-1:0] npu_out_fifo_din;
  logic              npu_collector_busy;
  logic              npu_layer_done;
  logic              npu_collector_overflow;
  modport collector (
    input  npu_sigmoid_dout, npu_sigmoid_dout_valid, npu_sched_sigmoid_dest_sel,
           npu_sched_layer_size, npu_fb_fifo_rd_en, npu_out_fifo_full,
    output npu_fb_fifo_dout, npu_fb_fifo_empty, npu_fb_fifo_full, npu_fb_fifo_count,
           npu_out_fifo_wr_en, npu_out_fifo_din, npu_collector_busy, npu_layer_done,
           npu_collector_overflow
  );
  modport env (
    output npu_sigmoid_dout, npu_sigmoid_dout_valid, npu_sched_sigmoid_dest_sel,
           npu_sched_layer_size, npu_fb_fifo_rd_en, npu_out_fifo_full,
    input  npu_fb_fifo_dout, npu_fb_fifo_empty, npu_fb_fifo_full, npu_fb_fifo_count,
           npu_out_fifo_wr_en, npu_out_fifo_din, npu_collector_busy, npu_layer_done,
           npu_collector_overflow
  );
endinterface

// File: rtl/npu_sync_fifo.sv
// npu_sync_fifo: first-word-fall-through synchronous FIFO; head reads 0 while empty
module npu_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [W-1:0]           din_i,
  input  logic                   rd_en_i,
  output logic [W-1:0]           dout_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_wr, do_rd;
  assign do_wr   = wr_en_i && !full_o;
  assign do_rd   = rd_en_i && !empty_o;
  assign cnt_d   = cnt_q + CW'(do_wr) - CW'(do_rd);
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign count_o = cnt_q;
  assign dout_o  = empty_o ? '0 : mem_q[rp_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_wr) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/npu_sigmoid_collector.sv
// npu_sigmoid_collector: routes sigmoid results to the feedback FIFO or the external output FIFO,
// with a one-word hold for output backpressure, layer-completion tracking and a sticky drop flag.
module npu_sigmoid_collector
  import npu_sigmoid_collector_pkg::*;
#(
  parameter int DATA_W   = NPU_DATA_W,
  parameter int FB_DEPTH = NPU_FB_DEPTH,
  parameter int CNT_W    = NPU_CNT_W
) (
  input logic                   CLK,
  input logic                   npu_rst_n,
  npu_sigmoid_collector_if.collector bus
);
  localparam int FB_CW = fb_cw(FB_DEPTH);
  localparam logic [FB_CW-1:0] BUSY_TH = FB_CW'(FB_DEPTH - 2);
  logic              fb_full, fb_empty;
  logic [FB_CW-1:0]  fb_count;
  logic [DATA_W-1:0] fb_dout;
  logic              vld, to_out, out_full, acc_fb, acc_out, acc, drop, last;
  out_state_e        st_q;
  logic              wr_q, done_q, ovf_q;
  logic [DATA_W-1:0] din_q, hold_q, word;
  logic [CNT_W-1:0]  cnt_q, cnt_d, size_q, size_eff;
  assign word     = bus.npu_sigmoid_dout;
  assign vld      = bus.npu_sigmoid_dout_valid;
  assign out_full = bus.npu_out_fifo_full;
  assign to_out   = bus.npu_sched_sigmoid_dest_sel == DEST_OUT;
  assign acc_fb   = vld && !to_out && !fb_full;
  assign acc_out  = vld && to_out && st_q == ST_PASS;
  assign acc      = acc_fb || acc_out;
  assign drop     = vld && !acc;
  // a layer size of 0 wraps cnt_d to 0 after 2^CNT_W words, giving the full-range layer for free
  assign size_eff = cnt_q == '0 ? bus.npu_sched_layer_size : size_q;
  assign cnt_d    = cnt_q + 1'b1;
  assign last     = cnt_d == size_eff;
  npu_sync_fifo #(.W(DATA_W), .DEPTH(FB_DEPTH)) u_fb_fifo (
    .clk     (CLK),
    .rst_n   (npu_rst_n),
    .wr_en_i (acc_fb),
    .din_i   (word),
    .rd_en_i (bus.npu_fb_fifo_rd_en),
    .dout_o  (fb_dout),
    .empty_o (fb_empty),
    .full_o  (fb_full),
    .count_o (fb_count)
  );
  always_ff @(posedge CLK or negedge npu_rst_n)
    if (!npu_rst_n) begin
      st_q   <= ST_PASS;
      wr_q   <= 1'b0;
      din_q  <= '0;
      hold_q <= '0;
    end else if (st_q == ST_HOLD) begin
      wr_q <= !out_full;
      if (!out_full) begin
        din_q <= hold_q;
        st_q  <= ST_PASS;
      end
    end else begin
      wr_q <= acc_out && !out_full;
      if (acc_out && !out_full) din_q <= word;
      if (acc_out && out_full) begin
        hold_q <= word;
        st_q   <= ST_HOLD;
      end
    end
  always_ff @(posedge CLK or negedge npu_rst_n)
    if (!npu_rst_n) begin
      cnt_q  <= '0;
      size_q <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= acc && last;
      ovf_q  <= ovf_q || drop;
      if (vld && cnt_q == '0) size_q <= bus.npu_sched_layer_size;
      if (acc) cnt_q <= last ? '0 : cnt_d;
    end
  assign bus.npu_fb_fifo_dout       = fb_dout;
  assign bus.npu_fb_fifo_empty      = fb_empty;
  assign bus.npu_fb_fifo_full       = fb_full;
  assign bus.npu_fb_fifo_count      = fb_count;
  assign bus.npu_out_fifo_wr_en     = wr_q;
  assign bus.npu_out_fifo_din       = din_q;
  assign bus.npu_collector_busy     = st_q == ST_HOLD || fb_count >= BUSY_TH;
  assign bus.npu_layer_done         = done_q;
  assign bus.npu_collector_overflow = ovf_q;
endmodule

// File: tb/tb_npu_sigmoid_collector.sv
// tb_npu_sigmoid_collector: directed scoreboard bench for the sigmoid collector
module tb_npu_sigmoid_collector;
  logic CLK = 1'b0;
  logic rst_n = 1'b1;
  int tests = 0;
  int fails = 0;
  int dones = 0;
  int d0;
  logic [15:0] fb_q[$];
  logic [15:0] out_q[$];
  always #5 CLK = ~CLK;
  npu_sigmoid_collector_if #(.DATA_W(16), .CNT_W(8), .FB_CW(5)) bus ();
  npu_sigmoid_collector #(.DATA_W(16), .FB_DEPTH(16), .CNT_W(8)) dut (
    .CLK       (CLK),
    .npu_rst_n (rst_n),
    .bus       (bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
    if (bus.npu_layer_done) dones++;
    if (bus.npu_out_fifo_wr_en) begin
      if (out_q.size() == 0) chk("unexpected_out_wr", 32'(bus.npu_out_fifo_wr_en), 0);
      else chk("out_din", 32'(bus.npu_out_fifo_din), 32'(out_q.pop_front()));
    end
  endtask
  task automatic idle_inputs();
    bus.npu_sigmoid_dout = '0;
    bus.npu_sigmoid_dout_valid = 1'b0;
    bus.npu_sched_sigmoid_dest_sel = 1'b0;
    bus.npu_fb_fifo_rd_en = 1'b0;
  endtask
  task automatic do_reset();
    idle_inputs();
    bus.npu_out_fifo_full = 1'b0;
    bus.npu_sched_layer_size = '0;
    @(posedge CLK);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ovf", 32'(bus.npu_collector_overflow), 0);
    chk("rst_count", 32'(bus.npu_fb_fifo_count), 0);
    fb_q.delete();
    out_q.delete();
    #1 rst_n = 1'b1;
  endtask
  task automatic send(input logic dest, input logic [15:0] w);
    bus.npu_sigmoid_dout_valid = 1'b1;
    bus.npu_sched_sigmoid_dest_sel = dest;
    bus.npu_sigmoid_dout = w;
    step();
    bus.npu_sigmoid_dout_valid = 1'b0;
  endtask
  task automatic drain(input string tag);
    while (fb_q.size() != 0) begin
      chk(tag, 32'(bus.npu_fb_fifo_dout), 32'(fb_q.pop_front()));
      bus.npu_fb_fifo_rd_en = 1'b1;
      step();
    end
    bus.npu_fb_fifo_rd_en = 1'b0;
    chk({tag, "_empty"}, 32'(bus.npu_fb_fifo_empty), 1);
  endtask
  initial begin
    idle_inputs();
    bus.npu_out_fifo_full = 1'b0;
    bus.npu_sched_layer_size = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_empty", 32'(bus.npu_fb_fifo_empty), 1);
    chk("reset_full", 32'(bus.npu_fb_fifo_full), 0);
    chk("reset_count", 32'(bus.npu_fb_fifo_count), 0);
    chk("reset_fb_dout", 32'(bus.npu_fb_fifo_dout), 0);
    chk("reset_wr_en", 32'(bus.npu_out_fifo_wr_en), 0);
    chk("reset_din", 32'(bus.npu_out_fifo_din), 0);
    chk("reset_busy", 32'(bus.npu_collector_busy), 0);
    chk("reset_done", 32'(bus.npu_layer_done), 0);
    chk("reset_ovf", 32'(bus.npu_collector_overflow), 0);
    #10 rst_n = 1'b1;
    // fill feedback FIFO, busy from 14 onward, then drain in order
    for (int i = 1; i <= 16; i++) begin
      fb_q.push_back(16'(i));
      send(1'b0, 16'(i));
      chk("fill_count", 32'(bus.npu_fb_fifo_count), 32'(i));
      chk("fill_busy", 32'(bus.npu_collector_busy), 32'(i >= 14));
    end
    chk("fill_full", 32'(bus.npu_fb_fifo_full), 1);
    drain("fill_pop");
    chk("drain_busy", 32'(bus.npu_collector_busy), 0);
    // output backpressure through HOLD
    do_reset();
    bus.npu_out_fifo_full = 1'b1;
    out_q.push_back(16'hABCD);
    send(1'b1, 16'hABCD);
    chk("hold_busy", 32'(bus.npu_collector_busy), 1);
    chk("hold_no_wr", 32'(bus.npu_out_fifo_wr_en), 0);
    step();
    chk("hold_no_wr2", 32'(bus.npu_out_fifo_wr_en), 0);
    bus.npu_out_fifo_full = 1'b0;
    step();
    chk("drain_wr", 32'(bus.npu_out_fifo_wr_en), 1);
    chk("drain_din", 32'(bus.npu_out_fifo_din), 'hABCD);
    chk("drain_busy", 32'(bus.npu_collector_busy), 0);
    step();
    chk("drain_wr_once", 32'(bus.npu_out_fifo_wr_en), 0);
    out_q.push_back(16'h1234);
    send(1'b1, 16'h1234);
    chk("pass_wr", 32'(bus.npu_out_fifo_wr_en), 1);
    chk("pass_empty_q", out_q.size(), 0);
    // layer completion with size 3, then size 2 proving the counter cleared
    do_reset();
    bus.npu_sched_layer_size = 8'd3;
    d0 = dones;
    for (int i = 1; i <= 3; i++) begin
      send(1'b0, 16'(16'h100 + i));
      chk("layer3_done", 32'(bus.npu_layer_done), 32'(i == 3));
    end
    step();
    chk("layer3_done_end", 32'(bus.npu_layer_done), 0);
    chk("layer3_pulses", dones - d0, 1);
    bus.npu_sched_layer_size = 8'd2;
    send(1'b0, 16'h201);
    chk("layer2_first", 32'(bus.npu_layer_done), 0);
    send(1'b0, 16'h202);
    chk("layer2_done", 32'(bus.npu_layer_done), 1);
    // overflow on full feedback FIFO
    do_reset();
    for (int i = 0; i < 16; i++) begin
      fb_q.push_back(16'(16'h300 + i));
      send(1'b0, 16'(16'h300 + i));
    end
    chk("ovf_before", 32'(bus.npu_collector_overflow), 0);
    send(1'b0, 16'hDEAD);
    chk("ovf_set", 32'(bus.npu_collector_overflow), 1);
    chk("ovf_count", 32'(bus.npu_fb_fifo_count), 16);
    step();
    step();
    drain("ovf_pop");
    chk("ovf_sticky", 32'(bus.npu_collector_overflow), 1);
    // simultaneous push/pop at count 5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fb_q.push_back(16'(16'h400 + i));
      send(1'b0, 16'(16'h400 + i));
    end
    for (int i = 0; i < 10; i++) begin
      chk("pp_head", 32'(bus.npu_fb_fifo_dout), 32'(fb_q.pop_front()));
      fb_q.push_back(16'(16'h500 + i));
      bus.npu_fb_fifo_rd_en = 1'b1;
      send(1'b0, 16'(16'h500 + i));
      bus.npu_fb_fifo_rd_en = 1'b0;
      chk("pp_count", 32'(bus.npu_fb_fifo_count), 5);
    end
    drain("pp_pop");
    // reset while holding a word discards it
    do_reset();
    bus.npu_out_fifo_full = 1'b1;
    out_q.push_back(16'h5555);
    send(1'b1, 16'h5555);
    chk("hr_busy", 32'(bus.npu_collector_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("hr_busy_rst", 32'(bus.npu_collector_busy), 0);
    chk("hr_wr_rst", 32'(bus.npu_out_fifo_wr_en), 0);
    chk("hr_din_rst", 32'(bus.npu_out_fifo_din), 0);
    chk("hr_empty_rst", 32'(bus.npu_fb_fifo_empty), 1);
    void'(out_q.pop_back());
    bus.npu_out_fifo_full = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hr_no_wr", 32'(bus.npu_out_fifo_wr_en), 0);
    end
    send(1'b0, 16'h0777);
    chk("post_rst_count", 32'(bus.npu_fb_fifo_count), 1);
    chk("post_rst_head", 32'(bus.npu_fb_fifo_dout), 'h777);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
